// File: rtl/router_pkg.sv
// Shared definitions for the router output-port reader.
// Contents:
//   HDR_LEN_W / HDR_ADDR_W - header field widths ({len, addr} in one byte)
//   ROUTER_TIMEOUT         - router soft-reset window in cycles
//   state_t                - packet reader FSM states
//   hdr_len / hdr_addr     - header field extraction
//   parity_step            - one step of the running 8-bit XOR parity
package router_pkg;

    localparam int HDR_LEN_W      = 6;
    localparam int HDR_ADDR_W     = 2;
    localparam int ROUTER_TIMEOUT = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        PAR  = 2'd3
    } state_t;

    function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [7:0] hdr);
        return hdr[7:2];
    endfunction

    function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[1:0];
    endfunction

    function automatic logic [7:0] parity_step(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/router_obuf.sv
// Small synchronous FIFO holding {last, byte} payload entries.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   flush         - drop all entries (pointers and count cleared)
//   push, push_data, push_last - write one entry
//   pop           - consume the head entry (ignored when empty)
//   head_valid, head_data, head_last - head entry; data reads 0 when empty
//   occupancy     - number of stored entries
module router_obuf #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     push_last,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [7:0]               head_data,
    output logic                     head_last,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [8:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_pop_s;
    logic          do_push_s;

    assign do_pop_s   = pop && (count_r != '0);
    // a push into a full buffer is allowed only when the head leaves in the same cycle
    assign do_push_s  = push && ((count_r != DEPTH_C) || do_pop_s);
    assign head_valid = (count_r != '0);
    assign head_data  = head_valid ? mem_r[rd_ptr_r][7:0] : 8'h00;
    assign head_last  = head_valid ? mem_r[rd_ptr_r][8] : 1'b0;
    assign occupancy  = count_r;

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 9'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= {push_last, push_data};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/router_port_reader.sv
// Consumer for one router output port: drains packets from the port FIFO,
// strips header and parity, streams the payload out and reports status.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   valid_out, data_out   - router FIFO non-empty flag and read data (1-cycle latency)
//   read_enb              - FIFO read strobe
//   out_data/out_valid/out_ready/out_last - payload byte stream
//   pkt_done              - one-cycle pulse after the parity byte is consumed
//   pkt_len, pkt_addr     - length/address of the last completed packet
//   parity_err, addr_err  - status of the last completed packet
//   timeout               - one-cycle pulse when the packet is abandoned
module router_port_reader
    import router_pkg::*;
#(
    parameter int PORT_ID     = 0,
    parameter int OBUF_DEPTH  = 4,
    parameter int TIMEOUT_CYC = ROUTER_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_out,
    input  logic [7:0]            data_out,
    output logic                  read_enb,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  pkt_done,
    output logic [HDR_LEN_W-1:0]  pkt_len,
    output logic [HDR_ADDR_W-1:0] pkt_addr,
    output logic                  parity_err,
    output logic                  addr_err,
    output logic                  timeout
);

    localparam int OCC_W  = $clog2(OBUF_DEPTH) + 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [OCC_W-1:0]      DEPTH_C     = OCC_W'(OBUF_DEPTH);
    localparam logic [TCNT_W-1:0]     TO_LAST_C   = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [HDR_ADDR_W-1:0] PORT_ADDR_C = HDR_ADDR_W'(PORT_ID);

    state_t                state_r;
    logic                  rd_pend_r;   // a read was issued last cycle; data_out is live now
    logic [HDR_LEN_W-1:0]  rem_r;       // payload bytes still to be received
    logic [7:0]            parity_r;
    logic [HDR_LEN_W-1:0]  hdr_len_r;
    logic [HDR_ADDR_W-1:0] hdr_addr_r;
    logic [TCNT_W-1:0]     tcnt_r;

    logic [OCC_W-1:0]      occ_s;
    logic [OCC_W-1:0]      pend_occ_s;
    logic [HDR_LEN_W-1:0]  pend_rem_s;
    logic [HDR_LEN_W-1:0]  in_len_s;
    logic                  rd_ok_s;
    logic                  to_fire_s;
    logic                  push_s;
    logic                  push_last_s;
    logic                  pop_s;

    assign in_len_s   = hdr_len(data_out);
    assign pend_occ_s = {{(OCC_W-1){1'b0}}, rd_pend_r};
    assign pend_rem_s = {{(HDR_LEN_W-1){1'b0}}, rd_pend_r};

    // Per-state read permission; buffer space counts the read already in flight.
    always_comb begin
        rd_ok_s = 1'b0;
        case (state_r)
            IDLE:    rd_ok_s = 1'b1;
            HDR:     rd_ok_s = (in_len_s != '0) && (occ_s < DEPTH_C);
            PAY:     rd_ok_s = (rem_r > pend_rem_s) && ((occ_s + pend_occ_s) < DEPTH_C);
            PAR:     rd_ok_s = !rd_pend_r;
            default: rd_ok_s = 1'b0;
        endcase
    end

    assign read_enb    = rd_ok_s && valid_out && !reset;
    assign to_fire_s   = valid_out && !read_enb && (tcnt_r == TO_LAST_C);
    assign push_s      = (state_r == PAY) && rd_pend_r && !to_fire_s;
    assign push_last_s = (rem_r == HDR_LEN_W'(1));
    assign pop_s       = out_valid && out_ready;

    router_obuf #(
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clock      (clock),
        .reset      (reset),
        .flush      (to_fire_s),
        .push       (push_s),
        .push_data  (data_out),
        .push_last  (push_last_s),
        .pop        (pop_s),
        .head_valid (out_valid),
        .head_data  (out_data),
        .head_last  (out_last),
        .occupancy  (occ_s)
    );

    // Packet FSM, parity, timeout counter and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            rd_pend_r  <= 1'b0;
            rem_r      <= '0;
            parity_r   <= 8'h00;
            hdr_len_r  <= '0;
            hdr_addr_r <= '0;
            tcnt_r     <= '0;
            pkt_done   <= 1'b0;
            pkt_len    <= '0;
            pkt_addr   <= '0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            timeout  <= 1'b0;
            if (valid_out && !read_enb && (tcnt_r != TO_LAST_C)) begin
                tcnt_r <= tcnt_r + TCNT_W'(1);
            end else begin
                tcnt_r <= '0;
            end
            if (to_fire_s) begin
                // the router soft-resets its FIFO now: drop the packet entirely
                timeout   <= 1'b1;
                state_r   <= IDLE;
                rd_pend_r <= 1'b0;
                rem_r     <= '0;
            end else begin
                rd_pend_r <= read_enb;
                case (state_r)
                    IDLE: begin
                        if (read_enb) begin
                            state_r <= HDR;
                        end
                    end
                    HDR: begin
                        hdr_len_r  <= in_len_s;
                        hdr_addr_r <= hdr_addr(data_out);
                        parity_r   <= data_out;
                        rem_r      <= in_len_s;
                        state_r    <= (in_len_s == '0) ? PAR : PAY;
                    end
                    PAY: begin
                        if (rd_pend_r) begin
                            parity_r <= parity_step(parity_r, data_out);
                            rem_r    <= rem_r - HDR_LEN_W'(1);
                            if (rem_r == HDR_LEN_W'(1)) begin
                                state_r <= PAR;
                            end
                        end
                    end
                    PAR: begin
                        if (rd_pend_r) begin
                            pkt_done   <= 1'b1;
                            pkt_len    <= hdr_len_r;
                            pkt_addr   <= hdr_addr_r;
                            parity_err <= (parity_r != data_out);
                            addr_err   <= (hdr_addr_r != PORT_ADDR_C);
                            state_r    <= IDLE;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_router_port_reader.sv
// Directed bench for router_port_reader: a queue models the router port FIFO
// (one-cycle read latency), accepted stream bytes and packet status are
// collected on the falling edge and compared against hand-computed values.
module tb_router_port_reader;

    logic       clock = 1'b0;
    logic       reset;
    logic       valid_out;
    logic [7:0] data_out;
    logic       read_enb;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       pkt_done;
    logic [5:0] pkt_len;
    logic [1:0] pkt_addr;
    logic       parity_err;
    logic       addr_err;
    logic       timeout;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] fifo_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    int         done_cnt = 0;
    int         to_cnt   = 0;
    int         run      = 0;
    int         to_run   = 0;
    logic [5:0] st_len;
    logic [1:0] st_addr;
    logic       st_perr;
    logic       st_aerr;

    always #5 clock = ~clock;

    router_port_reader #(
        .PORT_ID     (0),
        .OBUF_DEPTH  (4),
        .TIMEOUT_CYC (30)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .read_enb   (read_enb),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .pkt_addr   (pkt_addr),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .timeout    (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe on the falling edge, then model the FIFO read after the rising edge.
    task automatic cycle();
        logic rd;
        @(negedge clock);
        check("rd_no_valid", 32'(read_enb && !valid_out), 32'd0);
        if (out_valid && out_ready) begin
            rx_q.push_back({out_last, out_data});
        end
        if (pkt_done) begin
            done_cnt++;
            st_len  = pkt_len;
            st_addr = pkt_addr;
            st_perr = parity_err;
            st_aerr = addr_err;
        end
        if (timeout) begin
            to_cnt++;
            to_run = run;
            fifo_q.delete();
            valid_out = 1'b0;
        end
        if (valid_out && !read_enb) run++;
        else run = 0;
        rd = read_enb && valid_out;
        @(posedge clock);
        #1;
        if (rd) begin
            check("rd_underrun", 32'(fifo_q.size() == 0), 32'd0);
            if (fifo_q.size() != 0) data_out = fifo_q.pop_front();
        end
        valid_out = (fifo_q.size() != 0);
    endtask

    function automatic logic [7:0] model_par(input logic [7:0] hdr, input int n, input logic [7:0] seed);
        logic [7:0] p;
        p = hdr;
        for (int i = 0; i < n; i++) p = p ^ 8'(seed * (i + 1));
        return p;
    endfunction

    task automatic load_pkt(input logic [7:0] hdr, input int n, input logic [7:0] seed, input logic [7:0] par);
        logic [7:0] b;
        fifo_q.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            b = 8'(seed * (i + 1));
            fifo_q.push_back(b);
            exp_q.push_back({(i == n - 1), b});
        end
        fifo_q.push_back(par);
    endtask

    task automatic run_pkt(input string tag, input int stall_at, input int stall_len,
                           input logic [5:0] e_len, input logic [1:0] e_addr,
                           input logic e_perr, input logic e_aerr);
        int d0;
        int t0;
        int n;
        int nexp;
        d0   = done_cnt;
        t0   = to_cnt;
        n    = 0;
        nexp = exp_q.size();
        valid_out = (fifo_q.size() != 0);
        while (((done_cnt == d0) || (rx_q.size() < nexp)) && (n < 300)) begin
            out_ready = !((n >= stall_at) && (n < stall_at + stall_len));
            if ((stall_len > 0) && (n == stall_at + 6)) begin
                #1;
                check({tag, "_stall_rd"}, 32'(read_enb), 32'd0);
            end
            cycle();
            n++;
        end
        out_ready = 1'b1;
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_len"}, 32'(st_len), 32'(e_len));
        check({tag, "_addr"}, 32'(st_addr), 32'(e_addr));
        check({tag, "_perr"}, 32'(st_perr), 32'(e_perr));
        check({tag, "_aerr"}, 32'(st_aerr), 32'(e_aerr));
        check({tag, "_timeout"}, 32'(to_cnt - t0), 32'd0);
        check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(nexp));
        for (int i = 0; (i < nexp) && (i < rx_q.size()); i++) begin
            check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_read_enb"}, 32'(read_enb), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
        check({tag, "_pkt_len"}, 32'(pkt_len), 32'd0);
        check({tag, "_pkt_addr"}, 32'(pkt_addr), 32'd0);
        check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
        check({tag, "_addr_err"}, 32'(addr_err), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        int d0;
        int t0;
        int n;
        reset     = 1'b1;
        valid_out = 1'b0;
        data_out  = 8'h00;
        out_ready = 1'b0;
        repeat (3) cycle();
        check_zero("rst");
        reset     = 1'b0;
        out_ready = 1'b1;
        cycle();

        // parity 0x0C^0x11^0x22^0x33 = 0x0C
        load_pkt(8'h0C, 3, 8'h11, 8'h0C);
        run_pkt("clean", 0, 0, 6'd3, 2'd0, 1'b0, 1'b0);
        load_pkt(8'h0C, 3, 8'h11, 8'hFF);
        run_pkt("parity", 0, 0, 6'd3, 2'd0, 1'b1, 1'b0);
        // parity 0x0D^0x11^0x22^0x33 = 0x0D
        load_pkt(8'h0D, 3, 8'h11, 8'h0D);
        run_pkt("addr", 0, 0, 6'd3, 2'd1, 1'b0, 1'b1);
        load_pkt(8'h00, 0, 8'h00, 8'h00);
        run_pkt("len0", 0, 0, 6'd0, 2'd0, 1'b0, 1'b0);
        // 20-byte payload, sink stalled for 10 cycles mid-packet
        load_pkt(8'h50, 20, 8'h07, model_par(8'h50, 20, 8'h07));
        run_pkt("long", 5, 10, 6'd20, 2'd0, 1'b0, 1'b0);

        // sink never ready: buffer fills, then 30 unread cycles trigger the timeout
        load_pkt(8'h28, 10, 8'h05, 8'h00);
        exp_q.delete();
        out_ready = 1'b0;
        valid_out = 1'b1;
        d0 = done_cnt;
        t0 = to_cnt;
        n  = 0;
        while ((to_cnt == t0) && (n < 100)) begin
            cycle();
            n++;
        end
        check("to_seen", 32'(to_cnt - t0), 32'd1);
        check("to_run", 32'(to_run), 32'd30);
        cycle();
        check("to_pulse", 32'(timeout), 32'd0);
        check("to_flush", 32'(out_valid), 32'd0);
        check("to_nodone", 32'(done_cnt - d0), 32'd0);
        rx_q.delete();
        out_ready = 1'b1;
        load_pkt(8'h0C, 3, 8'h11, 8'h0C);
        run_pkt("after_to", 0, 0, 6'd3, 2'd0, 1'b0, 1'b0);

        // reset in the middle of a packet
        load_pkt(8'h0C, 3, 8'h11, 8'h0C);
        valid_out = 1'b1;
        repeat (4) cycle();
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        valid_out = 1'b0;
        cycle();
        check_zero("mid_rst");
        reset = 1'b0;
        rx_q.delete();
        cycle();
        load_pkt(8'h0D, 3, 8'h11, 8'h0D);
        run_pkt("after_rst", 0, 0, 6'd3, 2'd1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/router_port_reader.md
# router_port_reader

Downstream consumer for one router output port. Drains packets from the port FIFO through `valid_out_x`/`read_enb_x`/`data_out_x`, strips the header and parity bytes, and checks address and parity. Presents the payload as a ready/valid byte stream with per-packet status. One instance sits on each of the three router output ports.

## Interface
Parameters:
- `PORT_ID`, 0: port index (0..2); expected header address.
- `OBUF_DEPTH`, 4: output buffer entries; power of two, ≥2.
- `TIMEOUT_CYC`, 30: router soft-reset window in cycles.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_out` in 1: router port FIFO non-empty.
- `data_out` in 8: router FIFO read data; valid the cycle after `read_enb`.
- `read_enb` out 1: FIFO read strobe.
- `out_data` out 8: payload byte.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: sink accepts the byte when it is high together with `out_valid`.
- `out_last` out 1: last payload byte of the packet.
- `pkt_done` out 1: one-cycle pulse after the parity byte is consumed.
- `pkt_len` out 6: payload length of the completed packet; held until the next `pkt_done`.
- `pkt_addr` out 2: header address of the completed packet; held until the next `pkt_done`.
- `parity_err` out 1: qualified by `pkt_done`; computed parity ≠ received parity.
- `addr_err` out 1: qualified by `pkt_done`; header address ≠ `PORT_ID`.
- `timeout` out 1: one-cycle pulse; `TIMEOUT_CYC` consecutive unread `valid_out` cycles.

## Operation
- Packet format on `data_out`: header `{len[5:0], addr[1:0]}`, then `len` payload bytes, then one parity byte.
- Parity: XOR of the header and all payload bytes; 8-bit running XOR.
- FSM states and transitions:
  - IDLE: on `valid_out`, issue one read and go to HDR.
  - HDR: capture the header, load the remaining-byte counter with `len` and parity with the header, then go to PAY. If `len==0`, go to PAR instead.
  - PAY: read while allowed. Each returned byte is pushed to the output buffer and XORed into parity; the counter decrements. When the counter hits 0, go to PAR.
  - PAR: issue one read. The returned byte is compared against the running parity. Pulse `pkt_done`, update the status outputs, go to IDLE.
- `read_enb` is high only when all of the following hold:
  - state ∈ {IDLE, HDR-issue, PAY, PAR-issue};
  - `valid_out` is high;
  - in PAY, `occupancy + reads_in_flight < OBUF_DEPTH`;
  - no more reads are issued than bytes remain in the current section.
- Never read while `valid_out` is low. A mid-packet FIFO underrun stalls reads with no error.
- `out_last` is tagged on the buffer entry holding the final payload byte. With `len==0`, no stream output occurs.
- Errors never suppress stream output; the sink uses the `pkt_done` status.
- Timeout handling:
  - A counter increments while `valid_out && !read_enb`. It clears on a read or when `valid_out` is low.
  - When it reaches `TIMEOUT_CYC-1`: pulse `timeout`, abandon the packet (the router soft-resets that FIFO), return to IDLE, and flush unsent buffer entries.
  - No `pkt_done` is issued for an abandoned packet.
- Reset values:
  - All outputs 0, FSM in IDLE, buffer empty, counters 0.
  - A reset mid-packet discards everything.

## Timing
- Read latency: `read_enb` at cycle t gives data captured at t+1.
- Header read at t: first payload read at t+1 (back-to-back) if `valid_out` is high.
- Payload byte read at t: visible on `out_data` at t+2 when the buffer was empty (capture at t+1, buffer register at t+2).
- Sustained throughput: 1 byte/cycle with `out_ready` held high and the FIFO non-empty.
- `pkt_done` is asserted the cycle after the parity byte is captured. It may precede the drain of `out_last` from the buffer.
- Simultaneous buffer push and pop in one cycle: occupancy is unchanged.
- The next packet's header read may occur the cycle after `pkt_done`.

## Structure
- Package `router_pkg`:
  - constants `HDR_LEN_W=6`, `HDR_ADDR_W=2`, `ROUTER_TIMEOUT=30`;
  - FSM state enum `{IDLE,HDR,PAY,PAR}`.
- Sub-module `router_obuf`: synchronous FIFO of `{last, byte}` entries.
  - Interfaces: push, pop/valid, flush, occupancy.
  - Pointers wrap modulo `OBUF_DEPTH`.
- The top holds the FSM, counters, parity and timeout logic.

## Test plan
- Header 0x0C (len 3, addr 0) with `PORT_ID=0`; payload 0x11,0x22,0x33; parity 0x0C^0x11^0x22^0x33=0x0C; `out_ready=1`:
  - stream is 0x11,0x22,0x33 with `out_last` on 0x33;
  - `pkt_done` with `pkt_len=3`, both error flags 0.
- Same packet with parity byte 0xFF: identical stream, `parity_err=1`.
- Header 0x0D (addr 1) into `PORT_ID=0`: `addr_err=1`, payload still streamed.
- Header 0x00 (len 0) followed by parity 0x00: no `out_valid`, `pkt_done` with `pkt_len=0`, no errors.
- 20-byte payload, `out_ready=0` for 10 cycles mid-packet:
  - `read_enb` stops once `OBUF_DEPTH` bytes are buffered or in flight;
  - no byte is lost or duplicated;
  - no timeout occurs, since the stall is below 30 cycles.
- `out_ready=0` held with `valid_out=1` and the buffer full:
  - `timeout` pulses after 30 unread cycles, the buffer is flushed, state is IDLE;
  - the next clean packet is received correctly;
  - a reset asserted mid-packet returns all outputs to 0.
